load_store_unit: RTL and testbench

- Sits between the single-cycle datapath (ALU result and rt operand) and the word-addressed data memory.
- Performs byte and halfword loads, with sign or zero extension, by extracting the selected lanes from the combinational memory read word.
- Performs byte and halfword stores as a two-cycle read-modify-write, so the memory read-data path never feeds the memory write-data path in the same cycle. It stalls the CPU for one cycle while doing so.
- Word loads and word stores pass straight through in one cycle.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_lane_align.sv | 42 ++++
 rtl/load_store_unit.sv | 114 +++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and alignment helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_t;

  // Illegal size or an address not aligned to the access size.
  function automatic logic bad_size_or_align(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: bad_size_or_align = 1'b0;
      SZ_HALF: bad_size_or_align = lo[0];
      SZ_WORD: bad_size_or_align = (lo != 2'b00);
      default: bad_size_or_align = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_c,
  output logic [31:0] merge_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[{lane, 3'b000} +: 8];
    half_sel = rd_word[{lane[1], 4'b0000} +: 16];
    load_c   = '0;
    merge_c  = rd_word;
    case (size)
      SZ_BYTE: begin
        load_c = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        merge_c[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_c = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        merge_c[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SZ_WORD: begin
        load_c  = rd_word;
        merge_c = wdata;
      end
      default: begin
        load_c  = '0;
        merge_c = rd_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the single-cycle datapath and word-addressed data memory.
// Sub-word stores run as a two-cycle read-modify-write with a one-cycle stall.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_AW      = 8,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned HI_LSB = MEM_AW + 2;

  lsu_state_t  state_q, state_d;
  logic [31:0] buf_q;
  logic [31:0] addr_q;
  logic        capture_c;
  logic [31:0] word_addr_c;
  logic        range_err_c;
  logic        fault_c;
  logic [31:0] load_c;
  logic [31:0] merge_c;

  assign word_addr_c = {req_addr[31:2], 2'b00};
  assign range_err_c = CHECK_RANGE && ((req_addr >> HI_LSB) != 32'd0);
  assign fault_c     = (req_read & req_write) | range_err_c
                     | bad_size_or_align(req_size, req_addr[1:0]);

  lsu_lane_align u_align (
    .rd_word     (mem_rdata),
    .lane        (req_addr[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .load_c      (load_c),
    .merge_c     (merge_c)
  );

  // Next state and memory-side outputs; everything is forced low while in reset.
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    rdata     = '0;
    stall     = 1'b0;
    fault     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (req_read | req_write) begin
            if (fault_c) begin
              fault = 1'b1;
            end else if (req_read) begin
              mem_read = 1'b1;
              mem_addr = word_addr_c;
              rdata    = load_c;
            end else if (req_size == SZ_WORD) begin
              mem_write = 1'b1;
              mem_addr  = word_addr_c;
              mem_wdata = req_wdata;
            end else begin
              mem_read  = 1'b1;
              mem_addr  = word_addr_c;
              stall     = 1'b1;
              capture_c = 1'b1;
              state_d   = RMW_WR;
            end
          end
        end
        RMW_WR: begin
          mem_write = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = buf_q;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, merge buffer and latched word address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture_c) begin
        buf_q  <= merge_c;
        addr_q <= word_addr_c;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a word-array memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_read;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  int n_cmp;
  int n_err;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rdata        (rdata),
    .stall        (stall),
    .fault        (fault),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory fixture: combinational read, synchronous write, plus a backdoor port.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_fault(input bit rd, input bit wr, input int size, input logic [31:0] addr);
    return (rd && wr) || size == 3 || (size == 1 && addr % 2 != 0)
        || (size == 2 && addr % 4 != 0) || addr >= 32'd1024;
  endfunction

  function automatic logic [31:0] m_load(input int size, input bit uns, input logic [31:0] addr);
    longint w, v;
    int sh;
    w  = longint'(ref_mem[addr[9:2]]);
    sh = int'(addr % 4) * 8;
    v  = w;
    if (size == 0) begin
      v = (w >> sh) % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = (w >> sh) % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_merge(input int size, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    sh   = int'(addr % 4) * 8;
    mask = (size == 0 ? 32'hFF : 32'hFFFF) << sh;
    return (ref_mem[addr[9:2]] & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic set_idle();
    req_read = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
  endtask

  // Entry and exit at one time unit after a rising edge.
  task automatic poke(input int idx, input logic [31:0] val);
    bd_we = 1; bd_idx = 8'(idx); bd_data = val;
    @(posedge clk); #1;
    bd_we = 0;
    ref_mem[idx] = val;
  endtask

  task automatic do_op(input bit rd, input bit wr, input int size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] waddr, merged;
    waddr = addr & 32'hFFFF_FFFC;
    req_read = rd; req_write = wr; req_size = 2'(size); req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    if (!rd && !wr) begin
      check("idle_rd", 32'(mem_read), 0);
      check("idle_wr", 32'(mem_write), 0);
      check("idle_addr", mem_addr, 0);
      check("idle_rdata", rdata, 0);
      check("idle_stall", 32'(stall), 0);
      @(posedge clk); #1;
    end else if (m_fault(rd, wr, size, addr)) begin
      check("flt_fault", 32'(fault), 1);
      check("flt_rd", 32'(mem_read), 0);
      check("flt_wr", 32'(mem_write), 0);
      check("flt_rdata", rdata, 0);
      check("flt_stall", 32'(stall), 0);
      @(posedge clk); #1;
    end else if (rd) begin
      check("ld_rdata", rdata, m_load(size, uns, addr));
      check("ld_rd", 32'(mem_read), 1);
      check("ld_addr", mem_addr, waddr);
      check("ld_stall", 32'(stall), 0);
      check("ld_fault", 32'(fault), 0);
      @(posedge clk); #1;
    end else if (size == 2) begin
      check("sw_wr", 32'(mem_write), 1);
      check("sw_addr", mem_addr, waddr);
      check("sw_wdata", mem_wdata, wd);
      check("sw_stall", 32'(stall), 0);
      @(posedge clk); #1;
      ref_mem[addr[9:2]] = wd;
    end else begin
      merged = m_merge(size, addr, wd);
      check("rmw1_stall", 32'(stall), 1);
      check("rmw1_rd", 32'(mem_read), 1);
      check("rmw1_wr", 32'(mem_write), 0);
      check("rmw1_fault", 32'(fault), 0);
      @(posedge clk); #1;
      check("rmw2_wr", 32'(mem_write), 1);
      check("rmw2_rd", 32'(mem_read), 0);
      check("rmw2_addr", mem_addr, waddr);
      check("rmw2_wdata", mem_wdata, merged);
      check("rmw2_stall", 32'(stall), 0);
      check("rmw2_fault", 32'(fault), 0);
      @(posedge clk); #1;
      ref_mem[addr[9:2]] = merged;
    end
    set_idle();
  endtask

  initial begin
    int kind, size;
    bit rd, wr;
    logic [31:0] addr;
    n_cmp = 0; n_err = 0;
    bd_we = 0; bd_idx = 0; bd_data = 0;
    rst_n = 0;
    set_idle();
    req_write = 1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'hAB;
    @(posedge clk); #1;
    check("rst_rd", 32'(mem_read), 0);
    check("rst_wr", 32'(mem_write), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    set_idle();
    rst_n = 1;
    @(posedge clk); #1;

    // Directed loads
    poke(4, 32'h80FF7F01);
    do_op(1, 0, 0, 0, 32'h12, 0);
    do_op(1, 0, 0, 1, 32'h12, 0);
    do_op(1, 0, 1, 0, 32'h12, 0);
    do_op(1, 0, 1, 1, 32'h12, 0);
    do_op(1, 0, 0, 0, 32'h10, 0);
    do_op(1, 0, 2, 0, 32'h10, 0);
    check("lb_0x12_const", m_load(0, 0, 32'h12), 32'hFFFFFFFF);
    check("lh_0x12_const", m_load(1, 0, 32'h12), 32'hFFFF80FF);

    // Directed stores
    poke(4, 32'h11223344);
    do_op(0, 1, 0, 0, 32'h11, 32'hAB);
    do_op(1, 0, 2, 0, 32'h10, 0);
    check("sb_result", ref_mem[4], 32'h1122AB44);
    poke(5, 32'h0);
    do_op(0, 1, 1, 0, 32'h16, 32'hCAFE);
    check("sh_result", ref_mem[5], 32'hCAFE0000);
    do_op(0, 1, 2, 0, 32'h18, 32'hDEADBEEF);
    do_op(1, 0, 2, 0, 32'h18, 0);

    // Directed faults
    do_op(1, 0, 1, 0, 32'h13, 0);
    do_op(0, 1, 2, 0, 32'h16, 32'h1);
    do_op(1, 0, 3, 0, 32'h20, 0);
    do_op(1, 1, 2, 0, 32'h20, 32'h5);
    do_op(1, 0, 2, 0, 32'h400, 0);
    do_op(0, 0, 0, 0, 32'h0, 0);

    // Reset during the write cycle of a read-modify-write
    poke(8, 32'h12345678);
    req_write = 1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'hFF;
    #1;
    check("rstrmw_stall", 32'(stall), 1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("rstrmw_wr", 32'(mem_write), 0);
    check("rstrmw_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    check("rstrmw_wr2", 32'(mem_write), 0);
    set_idle();
    rst_n = 1;
    @(posedge clk); #1;
    do_op(1, 0, 2, 0, 32'h20, 0);
    check("rstrmw_mem", mem[8], 32'h12345678);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      kind = int'($urandom_range(0, 19));
      rd   = (kind < 9) || (kind == 19);
      wr   = (kind >= 9 && kind < 18) || (kind == 19);
      size = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      addr = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom)};
      if (size == 1 && $urandom_range(0, 1) == 1) addr[0] = 0;
      if (size == 2 && $urandom_range(0, 3) != 0) addr[1:0] = 0;
      if ($urandom_range(0, 24) == 0) addr[31:10] = 22'($urandom);
      do_op(rd, wr, size, 1'($urandom), addr, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
